// File: rtl/mmio_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single MMIO bus port.
// Each granted transaction is IDLE -> ACCESS (one bus strobe) -> RESP (done pulse).
module mmio_bus_arbiter #(
  parameter int ADDR_W = 21,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rd_data,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              mmio_cs,
  output logic              mmio_wr,
  output logic              mmio_rd,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [DATA_W-1:0] mmio_wr_data,
  input  logic [DATA_W-1:0] mmio_rd_data,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              take;
  logic              grant;
  logic              lat_wr;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wr_data;

  // Bus strobes and done pulses decode only from state and latched registers,
  // so no requester input reaches the bus combinationally.
  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    grant     = owner;
    mmio_cs   = 1'b0;
    mmio_wr   = 1'b0;
    mmio_rd   = 1'b0;
    m0_done   = 1'b0;
    m1_done   = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          take      = 1'b1;
          state_nxt = ACCESS;
          grant     = (m0_req && m1_req) ? ~owner : m1_req;
        end
      end
      ACCESS: begin
        state_nxt = RESP;
        mmio_cs   = 1'b1;
        mmio_wr   = lat_wr;
        mmio_rd   = ~lat_wr;
      end
      RESP: begin
        state_nxt = IDLE;
        m0_done   = ~owner;
        m1_done   = owner;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mmio_addr    = lat_addr;
  assign mmio_wr_data = lat_wr_data;

  // owner resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= 1'b1;
      lat_wr      <= 1'b0;
      lat_addr    <= '0;
      lat_wr_data <= '0;
    end else begin
      state <= state_nxt;
      if (take) begin
        owner       <= grant;
        lat_wr      <= grant ? m1_wr : m0_wr;
        lat_addr    <= grant ? m1_addr : m0_addr;
        lat_wr_data <= grant ? m1_wr_data : m0_wr_data;
      end
    end
  end

  // Read data is captured at the end of the strobe cycle into the winner's register only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_rd_data <= '0;
      m1_rd_data <= '0;
    end else if (state == ACCESS && !lat_wr) begin
      if (owner) m1_rd_data <= mmio_rd_data;
      else       m0_rd_data <= mmio_rd_data;
    end
  end

endmodule
